// File: rtl/axi_mem_responder_if.sv
//------------------------------------------------------------------------------
// Module      : axi_mem_responder_if
// Description : Single-beat AXI read/write channel bundle between a DMA master
//               and the memory responder.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface axi_mem_responder_if;
    logic [31:0] s_axi_araddr;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic [31:0] s_axi_awaddr;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic        s_axi_bvalid;
    logic        s_axi_bready;

    modport master (
        output s_axi_araddr, s_axi_arvalid, s_axi_rready,
        output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wvalid, s_axi_bready,
        input  s_axi_arready, s_axi_rdata, s_axi_rvalid,
        input  s_axi_awready, s_axi_wready, s_axi_bvalid
    );

    modport slave (
        input  s_axi_araddr, s_axi_arvalid, s_axi_rready,
        input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wvalid, s_axi_bready,
        output s_axi_arready, s_axi_rdata, s_axi_rvalid,
        output s_axi_awready, s_axi_wready, s_axi_bvalid
    );
endinterface

`default_nettype wire

// File: rtl/axi_mem_responder.sv
//------------------------------------------------------------------------------
// Module      : axi_mem_responder
// Description : Single-beat AXI memory slave with programmable read latency
//               and completed-transaction counters.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module axi_mem_responder #(
    parameter int DEPTH        = 256,
    parameter int READ_LATENCY = 2
) (
    input  wire logic              clk,
    input  wire logic              rst,
    axi_mem_responder_if.slave     bus,
    output logic        [15:0]     rd_count,
    output logic        [15:0]     wr_count
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_DATA = 2'd2
    } rstate_t;

    typedef enum logic [0:0] {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wstate_t;

    logic [31:0] mem [DEPTH];

    // Address bits outside the word index are deliberately ignored (aliasing).
    logic w_unused_addr;
    assign w_unused_addr = &{1'b0, bus.s_axi_araddr[31:AW+2], bus.s_axi_araddr[1:0],
                             bus.s_axi_awaddr[31:AW+2], bus.s_axi_awaddr[1:0]};

    logic [AW-1:0] w_ar_idx;
    logic [AW-1:0] w_aw_idx;
    assign w_ar_idx = bus.s_axi_araddr[AW+1:2];
    assign w_aw_idx = bus.s_axi_awaddr[AW+1:2];

    // ---------------- read path ----------------
    rstate_t       r_rstate, w_rstate_nxt;
    logic [3:0]    r_rcnt, w_rcnt_nxt;
    logic [AW-1:0] r_ridx, w_ridx_nxt;
    logic [31:0]   r_rdata;
    logic          w_rdata_load;
    logic [AW-1:0] w_rload_idx;
    logic          w_rd_done;

    always_comb begin
        w_rstate_nxt = r_rstate;
        w_rcnt_nxt   = r_rcnt;
        w_ridx_nxt   = r_ridx;
        w_rdata_load = 1'b0;
        w_rload_idx  = r_ridx;
        w_rd_done    = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                if (bus.s_axi_arvalid) begin
                    w_ridx_nxt = w_ar_idx;
                    if (READ_LATENCY == 1) begin
                        w_rstate_nxt = R_DATA;
                        w_rdata_load = 1'b1;
                        w_rload_idx  = w_ar_idx;
                    end else begin
                        w_rcnt_nxt   = 4'(READ_LATENCY - 1);
                        w_rstate_nxt = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (r_rcnt == 4'd1) begin
                    w_rstate_nxt = R_DATA;
                    w_rdata_load = 1'b1;
                end else begin
                    w_rcnt_nxt = r_rcnt - 4'd1;
                end
            end
            R_DATA: begin
                if (bus.s_axi_rready) begin
                    w_rstate_nxt = R_IDLE;
                    w_rd_done    = 1'b1;
                end
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rstate <= R_IDLE;
            r_rcnt   <= 4'd0;
            r_ridx   <= '0;
            r_rdata  <= 32'd0;
            rd_count <= 16'd0;
        end else begin
            r_rstate <= w_rstate_nxt;
            r_rcnt   <= w_rcnt_nxt;
            r_ridx   <= w_ridx_nxt;
            // Reads the pre-write contents when a write commits on this edge.
            if (w_rdata_load)
                r_rdata <= mem[w_rload_idx];
            if (w_rd_done)
                rd_count <= rd_count + 16'd1;
        end
    end

    // ---------------- write path ----------------
    wstate_t       r_wstate, w_wstate_nxt;
    logic          r_aw_got, w_aw_got_nxt;
    logic          r_w_got, w_w_got_nxt;
    logic [AW-1:0] r_awidx, w_awidx_nxt;
    logic [31:0]   r_wdata, w_wdata_nxt;
    logic          w_aw_hs, w_w_hs;
    logic          w_commit;
    logic [AW-1:0] w_wr_idx;
    logic [31:0]   w_wr_data;
    logic          w_wr_done;

    assign w_aw_hs = bus.s_axi_awvalid & bus.s_axi_awready;
    assign w_w_hs  = bus.s_axi_wvalid & bus.s_axi_wready;

    always_comb begin
        w_wstate_nxt = r_wstate;
        w_aw_got_nxt = r_aw_got;
        w_w_got_nxt  = r_w_got;
        w_awidx_nxt  = r_awidx;
        w_wdata_nxt  = r_wdata;
        w_commit     = 1'b0;
        w_wr_idx     = r_awidx;
        w_wr_data    = r_wdata;
        w_wr_done    = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                w_aw_got_nxt = r_aw_got | w_aw_hs;
                w_w_got_nxt  = r_w_got | w_w_hs;
                if (w_aw_hs) w_awidx_nxt = w_aw_idx;
                if (w_w_hs)  w_wdata_nxt = bus.s_axi_wdata;
                if (w_aw_got_nxt && w_w_got_nxt) begin
                    w_commit     = 1'b1;
                    w_wr_idx     = w_aw_hs ? w_aw_idx : r_awidx;
                    w_wr_data    = w_w_hs ? bus.s_axi_wdata : r_wdata;
                    w_wstate_nxt = W_RESP;
                end
            end
            W_RESP: begin
                if (bus.s_axi_bready) begin
                    w_wstate_nxt = W_IDLE;
                    w_aw_got_nxt = 1'b0;
                    w_w_got_nxt  = 1'b0;
                    w_wr_done    = 1'b1;
                end
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wstate <= W_IDLE;
            r_aw_got <= 1'b0;
            r_w_got  <= 1'b0;
            r_awidx  <= '0;
            r_wdata  <= 32'd0;
            wr_count <= 16'd0;
        end else begin
            r_wstate <= w_wstate_nxt;
            r_aw_got <= w_aw_got_nxt;
            r_w_got  <= w_w_got_nxt;
            r_awidx  <= w_awidx_nxt;
            r_wdata  <= w_wdata_nxt;
            if (w_wr_done)
                wr_count <= wr_count + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && w_commit)
            mem[w_wr_idx] <= w_wr_data;
    end

    assign bus.s_axi_arready = (r_rstate == R_IDLE);
    assign bus.s_axi_rvalid  = (r_rstate == R_DATA);
    assign bus.s_axi_rdata   = r_rdata;
    assign bus.s_axi_awready = (r_wstate == W_IDLE) & ~r_aw_got;
    assign bus.s_axi_wready  = (r_wstate == W_IDLE) & ~r_w_got;
    assign bus.s_axi_bvalid  = (r_wstate == W_RESP);

endmodule

`default_nettype wire

// File: tb/tb_axi_mem_responder.sv
//------------------------------------------------------------------------------
// Module      : tb_axi_mem_responder
// Description : Directed self-checking bench with a read-data scoreboard.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_axi_mem_responder;

    localparam int DEPTH        = 256;
    localparam int READ_LATENCY = 2;

    logic        clk;
    logic        rst;
    logic [15:0] rd_count;
    logic [15:0] wr_count;

    axi_mem_responder_if bus ();

    axi_mem_responder #(
        .DEPTH        (DEPTH),
        .READ_LATENCY (READ_LATENCY)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .rd_count (rd_count),
        .wr_count (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] model [DEPTH];
    logic [31:0] sb [$];
    logic [15:0] exp_rd = 16'd0;
    logic [15:0] exp_wr = 16'd0;
    logic [31:0] held;

    function automatic int widx(input logic [31:0] addr);
        return int'((addr >> 2) % DEPTH);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data);
        int n;
        bus.s_axi_awaddr  = addr;
        bus.s_axi_wdata   = data;
        bus.s_axi_awvalid = 1'b1;
        bus.s_axi_wvalid  = 1'b1;
        bus.s_axi_bready  = 1'b1;
        tick();
        bus.s_axi_awvalid = 1'b0;
        bus.s_axi_wvalid  = 1'b0;
        model[widx(addr)] = data;
        exp_wr++;
        n = 0;
        while (!bus.s_axi_bvalid && n < 16) begin
            tick();
            n++;
        end
        chk("wr_bvalid_seen", {31'd0, bus.s_axi_bvalid}, 32'd1);
        tick();
        bus.s_axi_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr);
        int n;
        bus.s_axi_araddr  = addr;
        bus.s_axi_arvalid = 1'b1;
        bus.s_axi_rready  = 1'b1;
        sb.push_back(model[widx(addr)]);
        n = 0;
        while (!bus.s_axi_arready && n < 16) begin
            tick();
            n++;
        end
        tick();
        bus.s_axi_arvalid = 1'b0;
        n = 0;
        while (!bus.s_axi_rvalid && n < 32) begin
            tick();
            n++;
        end
        chk("rd_rvalid_seen", {31'd0, bus.s_axi_rvalid}, 32'd1);
        chk("rd_data", bus.s_axi_rdata, sb.pop_front());
        exp_rd++;
        tick();
        bus.s_axi_rready = 1'b0;
    endtask

    initial begin
        // ---- reset with all valids asserted ----
        rst               = 1'b0;
        bus.s_axi_araddr  = 32'd0;
        bus.s_axi_arvalid = 1'b1;
        bus.s_axi_rready  = 1'b0;
        bus.s_axi_awaddr  = 32'd0;
        bus.s_axi_awvalid = 1'b1;
        bus.s_axi_wdata   = 32'hDEAD_BEEF;
        bus.s_axi_wvalid  = 1'b1;
        bus.s_axi_bready  = 1'b0;
        tick();
        tick();
        chk("rst_arready", {31'd0, bus.s_axi_arready}, 32'd1);
        chk("rst_awready", {31'd0, bus.s_axi_awready}, 32'd1);
        chk("rst_wready",  {31'd0, bus.s_axi_wready},  32'd1);
        chk("rst_rvalid",  {31'd0, bus.s_axi_rvalid},  32'd0);
        chk("rst_bvalid",  {31'd0, bus.s_axi_bvalid},  32'd0);
        chk("rst_rdata",   bus.s_axi_rdata, 32'd0);
        chk("rst_rd_count", {16'd0, rd_count}, 32'd0);
        chk("rst_wr_count", {16'd0, wr_count}, 32'd0);
        bus.s_axi_arvalid = 1'b0;
        bus.s_axi_awvalid = 1'b0;
        bus.s_axi_wvalid  = 1'b0;
        rst = 1'b1;
        tick();

        // ---- write 0x10 with AW and W together, then timed read-back ----
        bus.s_axi_awaddr  = 32'h10;
        bus.s_axi_wdata   = 32'hABCD_1234;
        bus.s_axi_awvalid = 1'b1;
        bus.s_axi_wvalid  = 1'b1;
        bus.s_axi_bready  = 1'b1;
        tick();
        bus.s_axi_awvalid = 1'b0;
        bus.s_axi_wvalid  = 1'b0;
        model[widx(32'h10)] = 32'hABCD_1234;
        exp_wr++;
        chk("wr_bvalid_lat",   {31'd0, bus.s_axi_bvalid},  32'd1);
        chk("wr_awready_resp", {31'd0, bus.s_axi_awready}, 32'd0);
        tick();
        bus.s_axi_bready = 1'b0;
        chk("wr_bvalid_clr",  {31'd0, bus.s_axi_bvalid},  32'd0);
        chk("wr_awready_ret", {31'd0, bus.s_axi_awready}, 32'd1);
        chk("wr_count_1",     {16'd0, wr_count}, {16'd0, exp_wr});

        bus.s_axi_araddr  = 32'h10;
        bus.s_axi_arvalid = 1'b1;
        bus.s_axi_rready  = 1'b1;
        sb.push_back(model[widx(32'h10)]);
        tick();
        bus.s_axi_arvalid = 1'b0;
        chk("rd_lat_wait",    {31'd0, bus.s_axi_rvalid},  32'd0);
        chk("rd_arready_busy", {31'd0, bus.s_axi_arready}, 32'd0);
        tick();
        chk("rd_lat_valid",   {31'd0, bus.s_axi_rvalid}, 32'd1);
        chk("rd_data_10",     bus.s_axi_rdata, sb.pop_front());
        exp_rd++;
        tick();
        bus.s_axi_rready = 1'b0;
        chk("rd_rvalid_clr",  {31'd0, bus.s_axi_rvalid},  32'd0);
        chk("rd_arready_ret", {31'd0, bus.s_axi_arready}, 32'd1);
        chk("rd_count_1",     {16'd0, rd_count}, {16'd0, exp_rd});

        // ---- split write: W three cycles ahead of AW ----
        bus.s_axi_wdata  = 32'h55AA_55AA;
        bus.s_axi_wvalid = 1'b1;
        bus.s_axi_bready = 1'b1;
        tick();
        bus.s_axi_wvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("split_wready",  {31'd0, bus.s_axi_wready},  32'd0);
            chk("split_awready", {31'd0, bus.s_axi_awready}, 32'd1);
            chk("split_bvalid",  {31'd0, bus.s_axi_bvalid},  32'd0);
            tick();
        end
        bus.s_axi_awaddr  = 32'h20;
        bus.s_axi_awvalid = 1'b1;
        tick();
        bus.s_axi_awvalid = 1'b0;
        model[widx(32'h20)] = 32'h55AA_55AA;
        exp_wr++;
        chk("split_bvalid_lat", {31'd0, bus.s_axi_bvalid}, 32'd1);
        tick();
        bus.s_axi_bready = 1'b0;
        chk("split_wr_count", {16'd0, wr_count}, {16'd0, exp_wr});
        axi_read(32'h20);
        chk("split_rd_count", {16'd0, rd_count}, {16'd0, exp_rd});

        // ---- backpressure on B and R ----
        bus.s_axi_awaddr  = 32'h30;
        bus.s_axi_wdata   = 32'h1234_5678;
        bus.s_axi_awvalid = 1'b1;
        bus.s_axi_wvalid  = 1'b1;
        bus.s_axi_bready  = 1'b0;
        tick();
        bus.s_axi_awvalid = 1'b0;
        bus.s_axi_wvalid  = 1'b0;
        model[widx(32'h30)] = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            chk("bp_bvalid",   {31'd0, bus.s_axi_bvalid},  32'd1);
            chk("bp_awready",  {31'd0, bus.s_axi_awready}, 32'd0);
            chk("bp_wready",   {31'd0, bus.s_axi_wready},  32'd0);
            chk("bp_wr_count", {16'd0, wr_count}, {16'd0, exp_wr});
            tick();
        end
        bus.s_axi_bready = 1'b1;
        tick();
        bus.s_axi_bready = 1'b0;
        exp_wr++;
        chk("bp_bvalid_clr",   {31'd0, bus.s_axi_bvalid}, 32'd0);
        chk("bp_wr_count_inc", {16'd0, wr_count}, {16'd0, exp_wr});

        bus.s_axi_araddr  = 32'h30;
        bus.s_axi_arvalid = 1'b1;
        bus.s_axi_rready  = 1'b0;
        sb.push_back(model[widx(32'h30)]);
        tick();
        bus.s_axi_arvalid = 1'b0;
        tick();
        held = sb.pop_front();
        for (int i = 0; i < 4; i++) begin
            chk("bp_rvalid",   {31'd0, bus.s_axi_rvalid},  32'd1);
            chk("bp_rdata",    bus.s_axi_rdata, held);
            chk("bp_arready",  {31'd0, bus.s_axi_arready}, 32'd0);
            chk("bp_rd_count", {16'd0, rd_count}, {16'd0, exp_rd});
            tick();
        end
        bus.s_axi_rready = 1'b1;
        tick();
        bus.s_axi_rready = 1'b0;
        exp_rd++;
        chk("bp_rvalid_clr",   {31'd0, bus.s_axi_rvalid}, 32'd0);
        chk("bp_rd_count_inc", {16'd0, rd_count}, {16'd0, exp_rd});

        // ---- aliasing and read-before-write ----
        axi_write(32'h0, 32'h1);
        bus.s_axi_araddr  = 32'h0;
        bus.s_axi_arvalid = 1'b1;
        bus.s_axi_rready  = 1'b1;
        sb.push_back(model[widx(32'h0)]);
        tick();
        bus.s_axi_arvalid = 1'b0;
        bus.s_axi_awaddr  = DEPTH * 4 + 3;
        bus.s_axi_wdata   = 32'h2;
        bus.s_axi_awvalid = 1'b1;
        bus.s_axi_wvalid  = 1'b1;
        bus.s_axi_bready  = 1'b1;
        tick();
        bus.s_axi_awvalid = 1'b0;
        bus.s_axi_wvalid  = 1'b0;
        model[widx(DEPTH * 4 + 3)] = 32'h2;
        chk("rbw_rvalid", {31'd0, bus.s_axi_rvalid}, 32'd1);
        chk("rbw_bvalid", {31'd0, bus.s_axi_bvalid}, 32'd1);
        chk("rbw_rdata",  bus.s_axi_rdata, sb.pop_front());
        tick();
        bus.s_axi_rready = 1'b0;
        bus.s_axi_bready = 1'b0;
        exp_rd++;
        exp_wr++;
        chk("both_rd_count", {16'd0, rd_count}, {16'd0, exp_rd});
        chk("both_wr_count", {16'd0, wr_count}, {16'd0, exp_wr});
        axi_read(32'h0);

        // ---- reset during R_WAIT with only AW captured ----
        bus.s_axi_araddr  = 32'h40;
        bus.s_axi_arvalid = 1'b1;
        bus.s_axi_awaddr  = 32'h44;
        bus.s_axi_awvalid = 1'b1;
        tick();
        bus.s_axi_arvalid = 1'b0;
        bus.s_axi_awvalid = 1'b0;
        chk("mid_awready_captured", {31'd0, bus.s_axi_awready}, 32'd0);
        rst               = 1'b0;
        bus.s_axi_awaddr  = 32'h0;
        bus.s_axi_wdata   = 32'hBAD0_BAD0;
        bus.s_axi_awvalid = 1'b1;
        bus.s_axi_wvalid  = 1'b1;
        tick();
        tick();
        bus.s_axi_awvalid = 1'b0;
        bus.s_axi_wvalid  = 1'b0;
        rst = 1'b1;
        exp_rd = 16'd0;
        exp_wr = 16'd0;
        chk("mid_arready",  {31'd0, bus.s_axi_arready}, 32'd1);
        chk("mid_awready",  {31'd0, bus.s_axi_awready}, 32'd1);
        chk("mid_wready",   {31'd0, bus.s_axi_wready},  32'd1);
        chk("mid_rvalid",   {31'd0, bus.s_axi_rvalid},  32'd0);
        chk("mid_bvalid",   {31'd0, bus.s_axi_bvalid},  32'd0);
        chk("mid_rd_count", {16'd0, rd_count}, 32'd0);
        chk("mid_wr_count", {16'd0, wr_count}, 32'd0);
        tick();
        chk("post_rvalid", {31'd0, bus.s_axi_rvalid}, 32'd0);
        chk("post_bvalid", {31'd0, bus.s_axi_bvalid}, 32'd0);
        axi_read(32'h0);
        axi_write(32'h44, 32'hCAFE_F00D);
        axi_read(32'h44);
        chk("final_rd_count", {16'd0, rd_count}, {16'd0, exp_rd});
        chk("final_wr_count", {16'd0, wr_count}, {16'd0, exp_wr});

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
